// File: rtl/axis_ram_reader_pkg.sv
// Shared constants and FSM state type for the DDR ring-buffer stream reader.
package axis_ram_reader_pkg;

  localparam int         BURST_LEN      = 16;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_e;

endpackage

// File: rtl/axis_ram_reader_if.sv
// AXI3 read channels toward the HP port plus the AXIS output, bundled for one port.
interface axis_ram_reader_if #(
  parameter int AXI_ID_WIDTH     = 6,
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int AXIS_TDATA_WIDTH = 64
);
  logic [AXI_ID_WIDTH-1:0]     m_axi_arid;
  logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr;
  logic [3:0]                  m_axi_arlen;
  logic [2:0]                  m_axi_arsize;
  logic [1:0]                  m_axi_arburst;
  logic [3:0]                  m_axi_arcache;
  logic                        m_axi_arvalid;
  logic                        m_axi_arready;
  logic [AXI_ID_WIDTH-1:0]     m_axi_rid;
  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata;
  logic [1:0]                  m_axi_rresp;
  logic                        m_axi_rlast;
  logic                        m_axi_rvalid;
  logic                        m_axi_rready;
  logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata;
  logic                        m_axis_tvalid;
  logic                        m_axis_tready;

  modport master (
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arcache, m_axi_arvalid, m_axi_rready, m_axis_tdata, m_axis_tvalid,
    input  m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
           m_axi_rvalid, m_axis_tready
  );

  modport slave (
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arcache, m_axi_arvalid, m_axi_rready, m_axis_tdata, m_axis_tvalid,
    output m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
           m_axi_rvalid, m_axis_tready
  );
endinterface

// File: rtl/axis_ram_reader_fifo.sv
// First-word-fall-through synchronous FIFO; dout is valid whenever empty is low.
module sync_fifo_fwft #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 512
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // The upstream space check must make overflow impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o));

endmodule

// File: rtl/axis_ram_reader.sv
// Reads a DDR ring buffer with single-outstanding 16-beat INCR bursts and replays it as AXI4-Stream.
module axis_ram_reader
  import axis_ram_reader_pkg::*;
#(
  parameter int ADDR_WIDTH       = 20,
  parameter int AXI_ID_WIDTH     = 6,
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int AXIS_TDATA_WIDTH = 64,
  parameter int FIFO_DEPTH       = 512
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0] cfg_data,
  input  logic                      cfg_enable,
  output logic [ADDR_WIDTH-1:0]     sts_data,
  output logic                      sts_error,
  axis_ram_reader_if.master         bus
);
  localparam int SIZE_LOG2 = $clog2(AXI_DATA_WIDTH / 8);
  localparam int CW        = $clog2(FIFO_DEPTH) + 1;

  state_e                      state_q;
  logic [ADDR_WIDTH-1:0]       ptr_q, ptr_d;
  logic [AXI_ID_WIDTH-1:0]     arid_q;
  logic [AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic                        arvalid_q, rready_q, err_q;
  logic                        wr_vld_q;
  logic [AXIS_TDATA_WIDTH-1:0] wr_data_q;

  logic                        beat_acc, space_ok, fifo_pop;
  logic                        fifo_empty, fifo_full;
  logic [CW-1:0]               fifo_count, occ;
  logic [AXIS_TDATA_WIDTH-1:0] fifo_dout;
  logic                        unused_ok;

  assign ptr_d    = ptr_q + ADDR_WIDTH'(BURST_LEN);
  assign araddr_d = cfg_data + (AXI_ADDR_WIDTH'(ptr_q) << SIZE_LOG2);
  assign beat_acc = rready_q && bus.m_axi_rvalid;

  // The beat still sitting in the write register counts against free space.
  assign occ      = fifo_count + CW'(wr_vld_q);
  assign space_ok = (occ <= CW'(FIFO_DEPTH - BURST_LEN));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (cfg_enable && space_ok) begin
          state_q   <= ADDR;
          arvalid_q <= 1'b1;
          araddr_q  <= araddr_d;
        end
        ADDR: if (bus.m_axi_arready) begin
          state_q   <= DATA;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          ptr_q     <= ptr_d;
        end
        DATA: if (bus.m_axi_rvalid && bus.m_axi_rlast) begin
          state_q  <= IDLE;
          rready_q <= 1'b0;
          arid_q   <= arid_q + AXI_ID_WIDTH'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Beats are registered once before the FIFO; errored beats are still forwarded.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_vld_q  <= 1'b0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_vld_q <= beat_acc;
      if (beat_acc) wr_data_q <= bus.m_axi_rdata;
      if (beat_acc && bus.m_axi_rresp != AXI_RESP_OKAY) err_q <= 1'b1;
    end
  end

  assign fifo_pop = !fifo_empty && bus.m_axis_tready;

  sync_fifo_fwft #(
    .WIDTH (AXIS_TDATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .push_i  (wr_vld_q),
    .din_i   (wr_data_q),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign bus.m_axi_arid    = arid_q;
  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arlen   = 4'(BURST_LEN - 1);
  assign bus.m_axi_arsize  = 3'(SIZE_LOG2);
  assign bus.m_axi_arburst = AXI_BURST_INCR;
  assign bus.m_axi_arcache = AXI_CACHE_BUF;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_rready  = rready_q;
  assign bus.m_axis_tdata  = fifo_dout;
  assign bus.m_axis_tvalid = !fifo_empty;

  assign sts_data  = ptr_q;
  assign sts_error = err_q;

  assign unused_ok = ^{bus.m_axi_rid, fifo_full};

endmodule

// File: tb/tb_axis_ram_reader.sv
// Directed bench: a small AXI read slave serves {beat byte address, beat sequence} words.
module tb_axis_ram_reader;
  localparam int AW = 6;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [31:0]     cfg_data;
  logic            cfg_enable;
  logic [AW-1:0]   sts_data;
  logic            sts_error;

  axis_ram_reader_if bus ();

  axis_ram_reader #(.ADDR_WIDTH(AW)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .cfg_data   (cfg_data),
    .cfg_enable (cfg_enable),
    .sts_data   (sts_data),
    .sts_error  (sts_error),
    .bus        (bus)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0]   addr;
    logic [5:0]    id;
    logic [3:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    logic [3:0]    cache;
    logic [AW-1:0] sts;
  } ar_t;

  ar_t         ar_log[$];
  logic [63:0] got[$];
  int          ar_delay = 0;
  int          err_beat = -1;
  int          n_chk = 0, n_pass = 0;
  int          exp_seq = 0;

  bit          busy, p_ar, p_r, p_pop;
  logic [31:0] b_addr;
  int          b_idx, ar_wait, seq;
  ar_t         p_arv;
  logic [63:0] p_data;

  // Slave + stream monitor: commit last edge's handshakes, drive, then predict the next edge.
  initial begin : env
    bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0;
    bus.m_axi_rresp = 2'b00;  bus.m_axi_rdata = '0;    bus.m_axi_rid = '0;
    busy = 0; b_idx = 0; ar_wait = 0; seq = 0; p_ar = 0; p_r = 0; p_pop = 0;
    b_addr = '0; p_data = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        busy = 0; b_idx = 0; ar_wait = 0; seq = 0;
        bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0;
      end else begin
        if (p_ar) begin
          p_arv.sts = sts_data;
          ar_log.push_back(p_arv);
          busy = 1; b_addr = p_arv.addr; b_idx = 0; ar_wait = 0;
        end
        if (p_r) begin
          b_idx++; seq++;
          if (b_idx == 16) busy = 0;
        end
        if (p_pop) got.push_back(p_data);
        bus.m_axi_arready = 1'b0;
        if (!busy && bus.m_axi_arvalid) begin
          if (ar_wait >= ar_delay) bus.m_axi_arready = 1'b1;
          else ar_wait++;
        end
        bus.m_axi_rvalid = busy;
        bus.m_axi_rlast  = busy && (b_idx == 15);
        bus.m_axi_rdata  = {b_addr + 32'(b_idx * 8), 32'(seq)};
        bus.m_axi_rresp  = (busy && b_idx == err_beat) ? 2'b10 : 2'b00;
      end
      #2;
      p_ar  = aresetn && bus.m_axi_arvalid && bus.m_axi_arready;
      p_r   = aresetn && bus.m_axi_rvalid && bus.m_axi_rready;
      p_pop = aresetn && bus.m_axis_tvalid && bus.m_axis_tready;
      p_data = bus.m_axis_tdata;
      p_arv.addr = bus.m_axi_araddr;  p_arv.id = bus.m_axi_arid;  p_arv.len = bus.m_axi_arlen;
      p_arv.size = bus.m_axi_arsize;  p_arv.burst = bus.m_axi_arburst;
      p_arv.cache = bus.m_axi_arcache; p_arv.sts = '0;
    end
  end

  task automatic tick();
    @(negedge aclk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_arvalid"}, 64'(bus.m_axi_arvalid), 0);
    chk({tag, "_rready"},  64'(bus.m_axi_rready),  0);
    chk({tag, "_tvalid"},  64'(bus.m_axis_tvalid), 0);
    chk({tag, "_arid"},    64'(bus.m_axi_arid),    0);
    chk({tag, "_sts_data"}, 64'(sts_data),         0);
    chk({tag, "_sts_error"}, 64'(sts_error),       0);
  endtask

  // Stop new bursts, let the FIFO empty, then compare every streamed word with the ring model.
  task automatic drain(input string tag);
    int quiet = 0;
    int bad = 0;
    logic [63:0] exp, first_obs, first_exp;
    first_obs = '0; first_exp = '0;
    cfg_enable = 1'b0;
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < 2000 && quiet < 3; i++) begin
      tick();
      if (!bus.m_axi_arvalid && !bus.m_axi_rready && !bus.m_axis_tvalid) quiet++;
      else quiet = 0;
    end
    chk({tag, "_drain"}, 64'(quiet >= 3), 1);
    chk({tag, "_nbeats"}, 64'(got.size()), 64'(16 * ar_log.size()));
    foreach (got[i]) begin
      exp = {cfg_data + 32'((exp_seq % 64) * 8), 32'(exp_seq)};
      if (got[i] !== exp) begin
        if (bad == 0) begin first_obs = got[i]; first_exp = exp; end
        bad++;
      end
      exp_seq++;
    end
    chk({tag, "_data"}, first_obs, first_exp);
    got.delete();
    ar_log.delete();
  endtask

  logic [31:0] a_hold;
  bit          stable;

  initial begin : main
    aresetn = 1'b0; cfg_data = 32'h1000_0000; cfg_enable = 1'b0; bus.m_axis_tready = 1'b1;
    tick(); tick();
    chk_reset("rst");

    // Basic streaming, burst fields and ring wrap.
    aresetn = 1'b1; cfg_enable = 1'b1;
    for (int i = 0; i < 400 && ar_log.size() < 5; i++) tick();
    chk("ar5_wait", 64'(ar_log.size() >= 5), 1);
    chk("ar0_addr",  64'(ar_log[0].addr),  64'h1000_0000);
    chk("ar0_len",   64'(ar_log[0].len),   15);
    chk("ar0_id",    64'(ar_log[0].id),    0);
    chk("ar0_size",  64'(ar_log[0].size),  3);
    chk("ar0_burst", 64'(ar_log[0].burst), 1);
    chk("ar0_cache", 64'(ar_log[0].cache), 3);
    chk("ar1_addr",  64'(ar_log[1].addr),  64'h1000_0080);
    chk("ar1_id",    64'(ar_log[1].id),    1);
    chk("sts0", 64'(ar_log[0].sts), 16);
    chk("sts1", 64'(ar_log[1].sts), 32);
    chk("sts2", 64'(ar_log[2].sts), 48);
    chk("sts3", 64'(ar_log[3].sts), 0);
    chk("ar4_wrap_addr", 64'(ar_log[4].addr), 64'h1000_0000);
    drain("basic");

    // Backpressure: FIFO space allows exactly 32 bursts.
    bus.m_axis_tready = 1'b0; cfg_enable = 1'b1;
    for (int i = 0; i < 1200 && ar_log.size() < 32; i++) tick();
    for (int i = 0; i < 60; i++) tick();
    chk("bp_bursts", 64'(ar_log.size()), 32);
    chk("bp_arvalid", 64'(bus.m_axi_arvalid), 0);
    chk("bp_tvalid", 64'(bus.m_axis_tvalid), 1);
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < 1200 && ar_log.size() < 36; i++) tick();
    chk("bp_resume", 64'(ar_log.size() >= 36), 1);
    drain("bp");

    // Slow arready: AR stays stable; enable dropped in DATA finishes the burst only.
    ar_delay = 5; cfg_enable = 1'b1;
    for (int i = 0; i < 50 && !bus.m_axi_arvalid; i++) tick();
    a_hold = bus.m_axi_araddr;
    chk("slow_araddr", 64'(a_hold), 64'(cfg_data + 32'((exp_seq % 64) * 8)));
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!bus.m_axi_arvalid || bus.m_axi_araddr !== a_hold) stable = 0;
    end
    chk("slow_ar_stable", 64'(stable), 1);
    for (int i = 0; i < 50 && !bus.m_axi_rready; i++) tick();
    chk("slow_data_wait", 64'(bus.m_axi_rready), 1);
    cfg_enable = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("slow_one_burst", 64'(ar_log.size()), 1);
    chk("slow_arvalid", 64'(bus.m_axi_arvalid), 0);
    ar_delay = 0;
    drain("slow");

    // Error response on beat 7 is sticky; data is still streamed.
    err_beat = 7; cfg_enable = 1'b1;
    for (int i = 0; i < 100 && !(bus.m_axi_rvalid && bus.m_axi_rready && bus.m_axi_rresp == 2'b10); i++) tick();
    chk("err_pre", 64'(sts_error), 0);
    tick();
    chk("err_set", 64'(sts_error), 1);
    cfg_enable = 1'b0;
    drain("err");
    chk("err_sticky", 64'(sts_error), 1);
    err_beat = -1;

    // Reset mid-burst at beat 9.
    cfg_enable = 1'b1;
    for (int i = 0; i < 100 && !(busy && b_idx == 9 && bus.m_axi_rready); i++) tick();
    chk("mid_wait", 64'(b_idx), 9);
    aresetn = 1'b0; cfg_data = 32'h2000_0000;
    #1;
    chk_reset("midrst");
    got.delete(); ar_log.delete(); exp_seq = 0;
    tick(); tick();
    aresetn = 1'b1;
    for (int i = 0; i < 50 && ar_log.size() < 1; i++) tick();
    chk("post_addr", 64'(ar_log[0].addr), 64'h2000_0000);
    chk("post_id", 64'(ar_log[0].id), 0);
    drain("post");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
